// File: rtl/alu_ex_stage.sv
// Registered 8-bit add/subtract execute stage with {Z,N,C,V} flags, a sticky
// overflow flag and a delivered-result counter, behind a one-deep valid/ready slot.

// 8-bit ripple-carry adder/subtractor. For subtraction B is inverted and the
// carry-in is 1, so C_B = 1 means "no borrow".
module alu_addsub8 (
    output logic       overflow,
    output logic [7:0] S_D,
    output logic       C_B,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       operator
);
    logic [7:0] b_eff;
    logic [8:0] carry;

    always_comb begin
        b_eff    = B ^ {8{operator}};
        carry    = '0;
        carry[0] = operator;
        S_D      = '0;
        for (int i = 0; i < 8; i++) begin
            S_D[i]       = A[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
        end
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign C_B      = carry[8];
    assign overflow = carry[7] ^ carry[8];
endmodule

module alu_ex_stage #(
    parameter int STICKY_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_res,
    output logic [3:0] out_flags,
    output logic       sticky_ovf,
    input  logic       ovf_clr,
    output logic [7:0] op_count
);
    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. Producers hold data stable while valid && !ready; ready never
    // depends on the same side's valid (in_ready looks only at out_valid and
    // out_ready), so there is no combinational loop through the handshake.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       add_ovf;
    logic [7:0] add_sum;
    logic       add_carry;

    logic       accept;
    logic       deliver;
    logic [3:0] flags_d;

    alu_addsub8 u_addsub (
        .overflow (add_ovf),
        .S_D      (add_sum),
        .C_B      (add_carry),
        .A        (in_a),
        .B        (in_b),
        .operator (in_op)
    );

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign flags_d   = {(add_sum == 8'h00), add_sum[7], add_carry, add_ovf};

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (out_ready && !in_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers load only on an accepted operand set and otherwise hold,
    // including after the slot empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_res   <= '0;
            out_flags <= '0;
        end else if (accept) begin
            out_res   <= add_sum;
            out_flags <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (deliver) begin
            op_count <= op_count + 8'd1;
        end
    end

    generate
        if (STICKY_EN != 0) begin : g_sticky
            // A new overflow wins over a clear arriving on the same edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sticky_ovf <= 1'b0;
                end else if (accept && add_ovf) begin
                    sticky_ovf <= 1'b1;
                end else if (ovf_clr) begin
                    sticky_ovf <= 1'b0;
                end
            end
        end else begin : g_no_sticky
            assign sticky_ovf = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: a reference arithmetic model feeds an
// expected-result queue that is popped whenever the stage delivers a result.
module tb_alu_ex_stage;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic [3:0] out_flags;
    logic       sticky_ovf;
    logic       ovf_clr;
    logic [7:0] op_count;

    int tests_run = 0;
    int fails     = 0;

    logic [11:0] exp_q[$];
    logic        exp_valid;
    logic [7:0]  exp_count;
    logic        exp_sticky;
    logic [7:0]  last_res;

    alu_ex_stage #(.STICKY_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_flags  (out_flags),
        .sticky_ovf (sticky_ovf),
        .ovf_clr    (ovf_clr),
        .op_count   (op_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: {res[7:0], Z, N, C, V} from plain 9-bit arithmetic.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
        logic [8:0] t;
        logic       v;
        if (!op) begin
            t = {1'b0, a} + {1'b0, b};
            v = (a[7] == b[7]) && (t[7] != a[7]);
        end else begin
            t = {1'b0, a} + {1'b0, ~b} + 9'd1;
            v = (a[7] != b[7]) && (t[7] != a[7]);
        end
        return {t[7:0], (t[7:0] == 8'h00), t[7], t[8], v};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_valid  = 1'b0;
        exp_count  = 8'h00;
        exp_sticky = 1'b0;
        last_res   = 8'h00;
    endtask

    // ---------------- driver + scoreboard ----------------
    // Drives one cycle of stimulus, scores the output side before the edge,
    // updates the model for the edge, then checks registered status after it.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic op, input logic ordy, input logic clr);
        logic        exp_rdy;
        logic        acc;
        logic        dlv;
        logic [11:0] item;
        logic [11:0] got;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        exp_rdy = !exp_valid || ordy;
        got     = {out_res, out_flags};
        tests_run++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL in_ready: got %b, required %b", in_ready, exp_rdy);
        end
        tests_run++;
        if (out_valid !== exp_valid) begin
            fails++;
            $display("FAIL out_valid: got %b, required %b", out_valid, exp_valid);
        end
        acc = v && exp_rdy;
        dlv = exp_valid && ordy;
        if (exp_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: got result %h with empty expected queue, required none", got);
            end else begin
                item = dlv ? exp_q.pop_front() : exp_q[0];
                if (got !== item) begin
                    fails++;
                    $display("FAIL result: got res=%h flags=%b, required res=%h flags=%b",
                             got[11:4], got[3:0], item[11:4], item[3:0]);
                end
            end
        end
        if (acc) begin
            item = model(a, b, op);
            exp_q.push_back(item);
            last_res = item[11:4];
        end
        if (acc && item[0]) exp_sticky = 1'b1;
        else if (clr)       exp_sticky = 1'b0;
        if (dlv) exp_count = exp_count + 8'd1;
        exp_valid = acc ? 1'b1 : (dlv ? 1'b0 : exp_valid);
        @(posedge clk);
        #1;
        tests_run++;
        if (sticky_ovf !== exp_sticky) begin
            fails++;
            $display("FAIL sticky_ovf: got %b, required %b", sticky_ovf, exp_sticky);
        end
        tests_run++;
        if (op_count !== exp_count) begin
            fails++;
            $display("FAIL op_count: got %0d, required %0d", op_count, exp_count);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_valid && budget < 10) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
            budget++;
        end
        tests_run++;
        if (exp_valid || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results pending, required 0", exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 1'b0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #2;
        tests_run++;
        if ({out_valid, out_res, out_flags, sticky_ovf, op_count, in_ready} !== {1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got valid=%b res=%h flags=%b sticky=%b count=%h rdy=%b, required 0/00/0000/0/00/1",
                     out_valid, out_res, out_flags, sticky_ovf, op_count, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({out_valid, out_res, out_flags, sticky_ovf} !== {1'b1, 8'h80, 4'b0101, 1'b1}) begin
            fails++;
            $display("FAIL add_ovf: got valid=%b res=%h flags=%b sticky=%b, required 1/80/0101/1",
                     out_valid, out_res, out_flags, sticky_ovf);
        end
        drain();
    endtask

    task automatic test_sub();
        drive(1'b1, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if ({out_res, out_flags} !== {8'h00, 4'b1010}) begin
            fails++;
            $display("FAIL sub_zero: got res=%h flags=%b, required 00/1010", out_res, out_flags);
        end
        drive(1'b1, 8'h03, 8'h05, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if ({out_res, out_flags} !== {8'hFE, 4'b0100}) begin
            fails++;
            $display("FAIL sub_borrow: got res=%h flags=%b, required FE/0100", out_res, out_flags);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic [7:0] cnt;
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        held = out_res;
        cnt  = op_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h40 + i), 8'h01, 1'b0, 1'b0, 1'b0);
            tests_run++;
            if (out_res !== 8'h46 || op_count !== cnt || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold: got res=%h count=%0d rdy=%b, required 46/%0d/0",
                         out_res, op_count, in_ready, cnt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h50 + i), 8'h02, 1'b1, 1'b1, 1'b0);
            tests_run++;
            if (op_count !== 8'(cnt + 8'(i) + 8'd1)) begin
                fails++;
                $display("FAIL backpressure_release: got count=%0d, required %0d", op_count, cnt + i + 1);
            end
        end
        tests_run++;
        if (held !== 8'h46) begin
            fails++;
            $display("FAIL backpressure_first: got %h, required 46", held);
        end
        drain();
    endtask

    task automatic test_sticky_clear();
        drive(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (sticky_ovf !== 1'b1) begin
            fails++;
            $display("FAIL sticky_set_wins: got %b, required 1", sticky_ovf);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (sticky_ovf !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clear: got %b, required 0", sticky_ovf);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        drain();
        tests_run++;
        if (out_valid !== 1'b0 || out_res !== last_res) begin
            fails++;
            $display("FAIL idle_hold: got valid=%b res=%h, required 0/%h", out_valid, out_res, last_res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end
        drain();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i), 8'h01, 1'b0, 1'b1, 1'b0);
        end
        tests_run++;
        if (op_count !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_255: got %h, required ff", op_count);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (op_count !== 8'h00) begin
            fails++;
            $display("FAIL wrap_zero: got %h, required 00", op_count);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, op_count, sticky_ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_mid: got valid=%b count=%h sticky=%b rdy=%b, required 0/00/0/1",
                     out_valid, op_count, sticky_ovf, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_res !== 8'h30) begin
            fails++;
            $display("FAIL first_after_reset: got valid=%b res=%h, required 1/30", out_valid, out_res);
        end
        drain();
        tests_run++;
        if (op_count !== 8'h01) begin
            fails++;
            $display("FAIL count_after_reset: got %h, required 01", op_count);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_sticky_clear();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
- Parameters
  - REQ-001 The block SHALL have parameter STICKY_EN, default 1, meaning: 1 enables the sticky overflow flag; 0 ties sticky_ovf to 0.
- Ports
  - REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
  - REQ-003 rst  input  1  reset; asynchronous and active-high.
  - REQ-004 in_valid  input  1  the operand set on in_a, in_b and in_op is valid.
  - REQ-005 in_ready  output  1  the stage can accept an operand set this cycle.
  - REQ-006 in_a  input  8  operand A.
  - REQ-007 in_b  input  8  operand B.
  - REQ-008 in_op  input  1  operator: 0 = A+B, 1 = A-B (two's complement, B inverted with carry-in 1).
  - REQ-009 out_valid  output  1  the registered result is valid.
  - REQ-010 out_ready  input  1  the consumer accepts the result this cycle.
  - REQ-011 out_res  output  8  registered sum or difference.
  - REQ-012 out_flags  output  4  registered flags {Z, N, C, V}; bit 3 = Z.
  - REQ-013 sticky_ovf  output  1  set when any accepted operation overflowed.
  - REQ-014 ovf_clr  input  1  synchronous clear of sticky_ovf.
  - REQ-015 op_count  output  8  count of results delivered (out_valid && out_ready).

Function
- REQ-016 Arithmetic SHALL use one instance of the team's 8-bit ripple add/sub (ports: overflow, S_D, C_B, A, B, operator), driven combinationally from in_a, in_b and in_op.
- REQ-017 A transfer in SHALL occur when in_valid && in_ready; out_res, out_flags and out_valid=1 SHALL be loaded on that edge, giving 1-cycle latency.
- Flags
  - REQ-018 Z = (S_D == 0).
  - REQ-019 N = S_D[7].
  - REQ-020 C = C_B taken raw; for subtraction, C=1 means no borrow.
  - REQ-021 V = the adder's overflow output (carry into bit 7 XOR carry out).
- REQ-022 in_ready SHALL be combinational: !out_valid || out_ready.
- REQ-023 When out_valid && !out_ready, out_res and out_flags SHALL be held stable and no new operand SHALL be accepted.
- REQ-024 When out_valid && out_ready && in_valid on the same cycle, the new result SHALL replace the old one, giving back-to-back throughput of 1 per cycle.
- REQ-025 When out_valid && out_ready && !in_valid, out_valid SHALL deassert on the next edge; out_res and out_flags SHALL keep their last value.
- REQ-026 in_a, in_b and in_op SHALL be ignored when in_valid=0 or in_ready=0.
- REQ-027 sticky_ovf SHALL set on an accepted transfer whose V=1.
- REQ-028 sticky_ovf SHALL clear on an edge where ovf_clr=1.
- REQ-029 If set and clear coincide on the same edge, set SHALL win.
- REQ-030 op_count SHALL increment by 1 per delivered result and wrap from 255 to 0 without a flag.
- REQ-031 The block SHALL use a single state bit (out_valid) with two states, EMPTY and FULL.
  - EMPTY->FULL on a transfer in.
  - FULL->FULL on (out_ready && in_valid) or on !out_ready.
  - FULL->EMPTY on out_ready && !in_valid.

Reset
- REQ-032 While rst=1, out_valid, out_res, out_flags, sticky_ovf and op_count SHALL be 0 and in_ready SHALL be 1, asynchronously and regardless of clk.
- REQ-033 A result pending at reset assertion SHALL be discarded and not counted.
- REQ-034 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Verification
- REQ-035 in_a=0x7F, in_b=0x01, in_op=0 -> next cycle out_res=0x80, flags Z=0 N=1 C=0 V=1, sticky_ovf=1.
- REQ-036 in_a=0x05, in_b=0x05, in_op=1 -> out_res=0x00, Z=1 N=0 C=1 V=0; in_a=0x03, in_b=0x05, in_op=1 -> out_res=0xFE, Z=0 N=1 C=0 V=0.
- REQ-037 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_res held at its first value, op_count unchanged; then out_ready=1 -> one result per cycle, with op_count +1 each cycle.
- REQ-038 Overflow and clear: in_a=0x80, in_b=0x01, in_op=1 (overflow) accepted on the same edge as ovf_clr=1 -> sticky_ovf=1; the next cycle with ovf_clr=1 and no overflow -> sticky_ovf=0.
- REQ-039 Wrap: deliver 256 results -> op_count returns to 0x00.
- REQ-040 Reset mid-operation: assert rst between edges while out_valid=1 -> out_valid=0, op_count=0 and sticky_ovf=0 immediately, before the next edge.
